multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 8: the maximum number of cycles to wait for memory ready before a fault.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle pulse that leaves IDLE.
REQ-005 SHALL have port op_code, input, 6 bits: the decoded instruction field, bits 31:26.
REQ-006 SHALL have port func, input, 6 bits: the decoded instruction field, bits 5:0.
REQ-007 SHALL have port zero, input, 1 bit: the ALU result-equals-zero flag.
REQ-008 SHALL have ports imem_rdy and dmem_rdy, inputs, 1 bit each: memory completion strobes.
REQ-009 SHALL have outputs imem_req, ir_load, pc_write, alu_src_b, reg_dst, reg_write, mem_read, mem_write and mem_to_reg, 1 bit each: datapath controls.
REQ-010 SHALL have output pc_src, 2 bits: 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-011 SHALL have output alu_op, 4 bits: 0 = add, 1 = sub, 2 = and, 3 = or, 4 = sll, 5 = slt.
REQ-012 SHALL have outputs busy, halted, illegal and fault, 1 bit each: status.
REQ-013 SHALL have output instr_count, 32 bits: the retired-instruction count (see Configuration).

Function
REQ-014 SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT, encoded in 3 bits.
REQ-015 SHALL transition IDLE to FETCH on start=1 and otherwise hold IDLE.
REQ-016 SHALL behave in FETCH as follows: imem_req=1 held; on imem_rdy, pulse ir_load=1 and pc_write=1 with pc_src=00 in that same cycle, then go to DECODE.
REQ-017 SHALL spend exactly one cycle in DECODE, then go to EXEC.
REQ-018 SHALL take these DECODE branches instead: op_code 6'h3F goes to HALT with halted=1; an unsupported op_code, or op_code 6'h00 with an unsupported func, goes to HALT with illegal=1 and halted=1.
REQ-019 SHALL support the opcodes 00 (R-type), 08 (addi), 23 (lw), 2B (sw), 04 (beq) and 02 (j).
REQ-020 SHALL support the R-type funcs 20 (add), 22 (sub), 24 (and), 25 (or), 00 (sll) and 2A (slt).
REQ-021 SHALL drive EXEC as follows: R-type gives alu_op from func, alu_src_b=0, next WB; addi/lw/sw give alu_op=0, alu_src_b=1, with addi going to WB and lw/sw going to MEM.
REQ-022 SHALL handle beq in EXEC with alu_op=1 and pc_src=01, asserting pc_write only when zero=1, then go to FETCH.
REQ-023 SHALL handle j in EXEC with pc_src=10 and pc_write=1, then go to FETCH.
REQ-024 SHALL hold mem_read (lw) or mem_write (sw) in MEM until dmem_rdy, then send lw to WB and sw to FETCH.
REQ-025 SHALL hold WB for one cycle with reg_write=1, reg_dst=1 for R-type, mem_to_reg=1 for lw, then go to FETCH.
REQ-026 SHALL drive every control output, in states where it is not named, to 0, and alu_op to 0.
REQ-027 SHALL give the following latencies with zero-wait memory: R-type/addi 4 cycles, lw 5, sw 4, beq/j 3.
REQ-028 SHALL count wait cycles in FETCH/MEM with a wait counter that clears on state entry; reaching WAIT_MAX without ready goes to HALT with fault=1 and halted=1.
REQ-029 SHALL drive busy=1 in every state except IDLE and HALT.
REQ-030 SHALL exit HALT only through reset, ignoring start there.
REQ-031 SHALL ignore start outside IDLE.
REQ-032 SHALL ignore imem_rdy outside FETCH and dmem_rdy outside MEM.
REQ-033 SHALL latch illegal, fault and halted (sticky) until reset.

Reset
REQ-034 SHALL, on rst_n=0, asynchronously force the state to IDLE, clear the wait counter, instr_count, illegal, fault and halted, and drive all outputs to 0.
REQ-035 SHALL, on reset mid-instruction, abandon the instruction with no further pc_write/reg_write/mem_write.
REQ-036 SHALL resume on the first rising clk edge after rst_n deasserts.

Configuration
REQ-037 SHALL, with INSTR_COUNT_EN defined, increment instr_count by 1 on every retirement: the WB exit, the sw MEM exit, and the beq/j EXEC exit.
REQ-038 SHALL wrap instr_count from 32'hFFFFFFFF to 0.
REQ-039 SHALL, with INSTR_COUNT_EN undefined, still have the instr_count port, tied to 0, with no counter flops.

Verification
REQ-040 SHALL cover reset then start with add (op 00, func 20) and zero-wait memory -> FETCH, DECODE, EXEC, WB in 4 cycles, reg_write=1 for exactly one cycle with reg_dst=1, alu_op=0.
REQ-041 SHALL cover lw (op 23) with dmem_rdy delayed 3 cycles -> mem_read high for 4 cycles, then WB with mem_to_reg=1; total 8 cycles.
REQ-042 SHALL cover beq (op 04) with zero=1 and then zero=0 -> pc_write=1 with pc_src=01 in EXEC for the first, and pc_write=0 in EXEC for the second.
REQ-043 SHALL cover op 6'h15, and separately op 00 with func 3F -> illegal=1, halted=1, busy=0, with a later start ignored.
REQ-044 SHALL cover imem_rdy held at 0 with WAIT_MAX=8 -> fault=1 after 8 FETCH cycles; a subsequent rst_n pulse clears it and returns to IDLE.
REQ-045 SHALL cover, with INSTR_COUNT_EN defined, five zero-wait sw instructions -> instr_count=5; rst_n asserted mid-MEM -> instr_count=0 and mem_write=0 immediately.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle processor control FSM.
// States run IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. The
// datapath control outputs are decoded from the current state, the opcode and
// func captured at the end of DECODE, and the live zero / ready strobes.
// Memory waits in FETCH and MEM are bounded by WAIT_MAX. A timeout, a halt
// opcode or an unsupported instruction parks the FSM in HALT. Only rst_n
// leaves HALT.
// Optional feature: define INSTR_COUNT_EN to build the retired-instruction
// counter. Without it, instr_count is tied to zero.
module multicycle_control #(
  parameter int WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  op_code,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        imem_rdy,
  input  logic        dmem_rdy,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic        fault,
  output logic [31:0] instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // The wait counter only needs to reach WAIT_MAX-1. The timeout is taken on that value.
  localparam int             WCW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

  logic [2:0]     state_r;
  logic [2:0]     next_state_s;
  logic [WCW-1:0] wait_cnt_r;
  logic [5:0]     op_r;
  logic [5:0]     func_r;
  logic           illegal_r;
  logic           fault_r;
  logic           halted_r;
  logic           set_illegal_s;
  logic           set_fault_s;

  // Map an R-type func field to its ALU operation. Unknown funcs map to add.
  function automatic logic [3:0] func_alu_op(input logic [5:0] fn);
    logic [3:0] op;
    case (fn)
      FN_ADD:  op = 4'd0;
      FN_SUB:  op = 4'd1;
      FN_AND:  op = 4'd2;
      FN_OR:   op = 4'd3;
      FN_SLL:  op = 4'd4;
      FN_SLT:  op = 4'd5;
      default: op = 4'd0;
    endcase
    return op;
  endfunction

  // True when the opcode is supported and, for R-type, the func is supported too.
  function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL, FN_SLT: ok = 1'b1;
          default:                                       ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Next-state selection and requests to set the sticky illegal and fault flags.
  always_comb begin
    next_state_s  = state_r;
    set_illegal_s = 1'b0;
    set_fault_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem_rdy) begin
          next_state_s = S_DECODE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          next_state_s = S_HALT;
          set_fault_s  = 1'b1;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (op_code == OP_HALT) begin
          next_state_s = S_HALT;
        end else if (!instr_legal(op_code, func)) begin
          next_state_s  = S_HALT;
          set_illegal_s = 1'b1;
        end else begin
          next_state_s = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_r)
          OP_RTYPE, OP_ADDI: next_state_s = S_WB;
          OP_LW, OP_SW:      next_state_s = S_MEM;
          OP_BEQ, OP_J:      next_state_s = S_FETCH;
          default: begin
            next_state_s  = S_HALT;
            set_illegal_s = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_rdy) begin
          if (op_r == OP_LW) begin
            next_state_s = S_WB;
          end else begin
            next_state_s = S_FETCH;
          end
        end else if (wait_cnt_r == WAIT_LAST) begin
          next_state_s = S_HALT;
          set_fault_s  = 1'b1;
        end else begin
          next_state_s = S_MEM;
        end
      end
      S_WB:   next_state_s = S_FETCH;
      S_HALT: next_state_s = S_HALT;
      default: begin
        next_state_s = S_HALT;
        set_fault_s  = 1'b1;
      end
    endcase
  end

  // State register. Reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Wait counter. It clears on every state change and advances while FETCH or MEM stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {WCW{1'b0}};
    end else if (next_state_s != state_r) begin
      wait_cnt_r <= {WCW{1'b0}};
    end else if ((state_r == S_FETCH) || (state_r == S_MEM)) begin
      wait_cnt_r <= wait_cnt_r + WCW'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Capture the instruction fields at the end of DECODE for use by the later states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= 6'h00;
      func_r <= 6'h00;
    end else if (state_r == S_DECODE) begin
      op_r   <= op_code;
      func_r <= func;
    end else begin
      op_r   <= op_r;
      func_r <= func_r;
    end
  end

  // Sticky status flags. They are cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
      fault_r   <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      illegal_r <= illegal_r | set_illegal_s;
      fault_r   <= fault_r | set_fault_s;
      halted_r  <= halted_r | (next_state_s == S_HALT);
    end
  end

  assign illegal = illegal_r;
  assign fault   = fault_r;
  assign halted  = halted_r;
  assign busy    = (state_r != S_IDLE) && (state_r != S_HALT);

  // Datapath controls. Any control not driven by the current state stays at 0.
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_b  = 1'b0;
    alu_op     = 4'd0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          pc_src   = 2'b00;
        end else begin
          ir_load  = 1'b0;
          pc_write = 1'b0;
        end
      end
      S_EXEC: begin
        case (op_r)
          OP_RTYPE: begin
            alu_op    = func_alu_op(func_r);
            alu_src_b = 1'b0;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            alu_op    = 4'd0;
            alu_src_b = 1'b1;
          end
          OP_BEQ: begin
            alu_op = 4'd1;
            pc_src = 2'b01;
            if (zero) begin
              pc_write = 1'b1;
            end else begin
              pc_write = 1'b0;
            end
          end
          OP_J: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
          end
          default: begin
            alu_op = 4'd0;
          end
        endcase
      end
      S_MEM: begin
        if (op_r == OP_LW) begin
          mem_read = 1'b1;
        end else if (op_r == OP_SW) begin
          mem_write = 1'b1;
        end else begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_r == OP_RTYPE);
        mem_to_reg = (op_r == OP_LW);
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic        retire_s;
  logic [31:0] count_r;

  // An instruction retires when it leaves WB, when a store completes in MEM,
  // or when a beq or j leaves EXEC.
  assign retire_s = (state_r == S_WB) ||
                    ((state_r == S_MEM) && (op_r == OP_SW) && dmem_rdy) ||
                    ((state_r == S_EXEC) && ((op_r == OP_BEQ) || (op_r == OP_J)));

  // Retired-instruction counter. It wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 32'd0;
    end else if (retire_s) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign instr_count = count_r;
`else
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. It compares a packed snapshot of
// the control and status outputs, and instr_count, against hand-computed values.
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  op_code;
  logic [5:0]  func;
  logic        zero;
  logic        imem_rdy;
  logic        dmem_rdy;
  logic        imem_req;
  logic        ir_load;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_b;
  logic [3:0]  alu_op;
  logic        reg_dst;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic        fault;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;

  // Bit layout of the packed output snapshot
  localparam logic [31:0] B_FAULT = 32'h0000_0001;
  localparam logic [31:0] B_ILL   = 32'h0000_0002;
  localparam logic [31:0] B_HALT  = 32'h0000_0004;
  localparam logic [31:0] B_BUSY  = 32'h0000_0008;
  localparam logic [31:0] B_M2R   = 32'h0000_0010;
  localparam logic [31:0] B_MW    = 32'h0000_0020;
  localparam logic [31:0] B_MR    = 32'h0000_0040;
  localparam logic [31:0] B_RW    = 32'h0000_0080;
  localparam logic [31:0] B_RD    = 32'h0000_0100;
  localparam logic [31:0] A_SUB   = 32'h0000_0200;
  localparam logic [31:0] A_SLT   = 32'h0000_0A00;
  localparam logic [31:0] B_ASB   = 32'h0000_2000;
  localparam logic [31:0] PS_BR   = 32'h0000_4000;
  localparam logic [31:0] PS_J    = 32'h0000_8000;
  localparam logic [31:0] B_PCW   = 32'h0001_0000;
  localparam logic [31:0] B_IRL   = 32'h0002_0000;
  localparam logic [31:0] B_IMQ   = 32'h0004_0000;
  localparam logic [31:0] F_HIT   = B_IMQ | B_IRL | B_PCW | B_BUSY;

`ifdef INSTR_COUNT_EN
  localparam logic [31:0] CNT_RUN = 32'd8;
  localparam logic [31:0] CNT_SW5 = 32'd5;
`else
  localparam logic [31:0] CNT_RUN = 32'd0;
  localparam logic [31:0] CNT_SW5 = 32'd0;
`endif

  multicycle_control #(.WAIT_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code), .func(func),
    .zero(zero), .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
    .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .busy(busy), .halted(halted), .illegal(illegal), .fault(fault),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ctl_now();
    return {13'd0, imem_req, ir_load, pc_write, pc_src, alu_src_b, alu_op,
            reg_dst, reg_write, mem_read, mem_write, mem_to_reg,
            busy, halted, illegal, fault};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, ctl_now(), exp);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk(tag, ctl_now(), 32'd0);
    chk({tag, "_cnt"}, instr_count, 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_code = 6'h00; func = 6'h00; zero = 1'b0;
    imem_rdy = 1'b1; dmem_rdy = 1'b1;
    #2;
    chk("reset_ctl", ctl_now(), 32'd0);
    chk("reset_cnt", instr_count, 32'd0);
    #6 rst_n = 1'b1;

    // add: FETCH, DECODE, EXEC, WB
    cyc(); op_code = 6'h00; func = 6'h20; start = 1'b1; ctl("idle", 32'd0);
    cyc(); start = 1'b0; ctl("add_fetch", F_HIT);
    cyc(); ctl("add_decode", B_BUSY);
    cyc(); ctl("add_exec", B_BUSY);
    cyc(); ctl("add_wb", B_RW | B_RD | B_BUSY);
    op_code = 6'h23; dmem_rdy = 1'b0;

    // lw, with dmem_rdy arriving on the fourth MEM cycle
    cyc(); ctl("lw_fetch", F_HIT);
    cyc(); ctl("lw_decode", B_BUSY);
    cyc(); ctl("lw_exec", B_ASB | B_BUSY);
    for (int i = 0; i < 3; i++) begin
      cyc(); ctl("lw_mem_wait", B_MR | B_BUSY);
    end
    cyc(); dmem_rdy = 1'b1; ctl("lw_mem_rdy", B_MR | B_BUSY);
    cyc(); ctl("lw_wb", B_RW | B_M2R | B_BUSY);
    op_code = 6'h04; zero = 1'b1;

    // beq taken, then not taken
    cyc(); ctl("beq1_fetch", F_HIT);
    cyc(); ctl("beq1_decode", B_BUSY);
    cyc(); ctl("beq1_exec", B_PCW | PS_BR | A_SUB | B_BUSY);
    cyc(); zero = 1'b0; ctl("beq2_fetch", F_HIT);
    cyc(); ctl("beq2_decode", B_BUSY);
    cyc(); ctl("beq2_exec", PS_BR | A_SUB | B_BUSY);
    op_code = 6'h02;

    // j
    cyc(); ctl("j_fetch", F_HIT);
    cyc(); ctl("j_decode", B_BUSY);
    cyc(); ctl("j_exec", B_PCW | PS_J | B_BUSY);
    op_code = 6'h08;

    // addi
    cyc(); cyc(); cyc(); ctl("addi_exec", B_ASB | B_BUSY);
    cyc(); ctl("addi_wb", B_RW | B_BUSY);
    op_code = 6'h00; func = 6'h2A;

    // slt
    cyc(); cyc(); cyc(); ctl("slt_exec", A_SLT | B_BUSY);
    cyc(); ctl("slt_wb", B_RW | B_RD | B_BUSY);
    op_code = 6'h2B;

    // sw, zero-wait
    cyc(); cyc(); cyc(); ctl("sw_exec", B_ASB | B_BUSY);
    cyc(); ctl("sw_mem", B_MW | B_BUSY);
    cyc(); ctl("sw_next_fetch", F_HIT);
    chk("run_count", instr_count, CNT_RUN);
    op_code = 6'h15;

    // unsupported opcode; start must be ignored in HALT
    cyc(); ctl("ill_op_decode", B_BUSY);
    cyc(); ctl("ill_op_halt", B_HALT | B_ILL);
    start = 1'b1;
    cyc(); cyc(); cyc(); ctl("ill_op_start_ignored", B_HALT | B_ILL);
    start = 1'b0;
    reset_pulse("ill_op_reset");

    // R-type with unsupported func
    cyc(); op_code = 6'h00; func = 6'h3F; start = 1'b1; ctl("ill_fn_idle", 32'd0);
    cyc(); start = 1'b0; ctl("ill_fn_fetch", F_HIT);
    cyc(); ctl("ill_fn_decode", B_BUSY);
    cyc(); start = 1'b1; ctl("ill_fn_halt", B_HALT | B_ILL);
    cyc(); start = 1'b0; ctl("ill_fn_start_ignored", B_HALT | B_ILL);
    reset_pulse("ill_fn_reset");

    // halt opcode: halted without illegal
    cyc(); op_code = 6'h3F; func = 6'h20; start = 1'b1; ctl("hlt_idle", 32'd0);
    cyc(); start = 1'b0; cyc(); cyc(); ctl("hlt_halt", B_HALT);
    reset_pulse("hlt_reset");

    // instruction memory never ready: fault after 8 FETCH cycles
    cyc(); imem_rdy = 1'b0; op_code = 6'h00; start = 1'b1; ctl("flt_idle", 32'd0);
    cyc(); start = 1'b0; ctl("flt_fetch_first", B_IMQ | B_BUSY);
    for (int i = 0; i < 7; i++) begin
      cyc(); ctl("flt_fetch_wait", B_IMQ | B_BUSY);
    end
    cyc(); ctl("flt_halt", B_HALT | B_FAULT);
    reset_pulse("flt_reset");
    cyc(); ctl("flt_after_idle", 32'd0);

    // five zero-wait stores, then reset in the middle of a sixth
    imem_rdy = 1'b1; dmem_rdy = 1'b1; op_code = 6'h2B; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(); start = 1'b0;
    end
    cyc(); ctl("sw5_fetch", F_HIT);
    chk("sw5_count", instr_count, CNT_SW5);
    dmem_rdy = 1'b0;
    cyc(); cyc(); cyc(); ctl("sw6_mem", B_MW | B_BUSY);
    reset_pulse("sw6_mid_mem_reset");
    cyc(); ctl("final_idle", 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
